aqed_batch_monitor: RTL

- Synthesizable, parametrised transaction monitor that sits between an A-QED checker and a memory-core DUT.
- Gates per-batch write/read admission against a runtime depth and tracks batch boundaries.
- Checks the response bound: once the original transaction has issued, its completion must be seen before a bounded number of reads and writes has elapsed.
- Replaces ad-hoc formal-only counters; usable in simulation, emulation and FPV.

---
 rtl/aqed_batch_monitor_pkg.sv | 26 ++
 rtl/aqed_batch_monitor_if.sv | 22 ++
 rtl/aqed_batch_monitor_sat_cnt.sv | 38 +++
 rtl/aqed_batch_monitor.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/aqed_batch_monitor_pkg.sv
// Shared types and constants for the A-QED batch monitor slice.
package aqed_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_ERR    = 2'd3
  } mon_state_e;

  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_OUT_RATIO = 4;
  localparam int unsigned DEF_BND_W     = 20;
  localparam int unsigned DEF_WDOG_W    = 8;

  // log2 of a power-of-two ratio; turns the bound multiply into a shift
  function automatic int unsigned ratio_log2(input int unsigned ratio);
    int unsigned n;
    n = 0;
    for (int unsigned v = ratio; v > 1; v = v >> 1) begin
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/aqed_batch_monitor_if.sv
// Checker <-> monitor handshake bundle: admission requests/grants and
// original-transaction status.
interface aqed_batch_monitor_if;

  logic wen_req;
  logic ren_req;
  logic wen_ok;
  logic ren_ok;
  logic orig_issued;
  logic orig_done;

  modport master (
    output wen_req, ren_req, orig_issued, orig_done,
    input  wen_ok, ren_ok
  );

  modport slave (
    input  wen_req, ren_req, orig_issued, orig_done,
    output wen_ok, ren_ok
  );

endinterface

// File: rtl/aqed_batch_monitor_sat_cnt.sv
// Saturating up-counter with enable, clear and increment. It exposes the
// value it will hold after the coming edge, so a threshold on it can fire
// in the same cycle as the event that reaches it.
module aqed_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_nxt
);

  logic [W-1:0] cnt_q;

  // next value: clear wins over increment, increment stops at all-ones
  always_comb begin
    cnt_nxt = cnt_q;
    if (en) begin
      if (clr) begin
        cnt_nxt = '0;
      end else if (inc && (cnt_q != '1)) begin
        cnt_nxt = cnt_q + 1'b1;
      end
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end

endmodule

// File: rtl/aqed_batch_monitor.sv
// A-QED batch monitor: gates write/read admission per batch of 'depth'
// transactions, pulses batch_done at batch completion and flags a
// response-bound violation on the original transaction.
// Optional watchdog on starved requests: define AQED_BATCH_MON_WDOG_EN.
module aqed_batch_monitor
  import aqed_mon_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned OUT_RATIO = DEF_OUT_RATIO,
  parameter int unsigned BND_W     = DEF_BND_W,
  parameter int unsigned WDOG_W    = DEF_WDOG_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic [CNT_W-1:0]     depth,
  aqed_batch_monitor_if.slave  bus,
  output logic [CNT_W-1:0]     count_wen,
  output logic [CNT_W-1:0]     count_ren,
  output logic                 batch_done,
  output logic                 bound_err,
  output logic                 wdog_err,
  output logic [1:0]           state
);

  localparam int unsigned OR_LOG2 = ratio_log2(OUT_RATIO);

  mon_state_e       st_q, st_d;
  logic             in_batch;
  logic             wen_ok, ren_ok;
  logic [CNT_W-1:0] wnext, rnext;
  logic             w_full, r_full, batch_cmp;
  logic [BND_W-1:0] out_nxt, in_nxt, bound_thr;
  logic             rdy_seen, bound_set, wdog_set;

  assign in_batch  = (st_q == ST_ACTIVE) || (st_q == ST_HOLD);
  assign wen_ok    = bus.wen_req & clk_en & in_batch & (count_wen < depth);
  assign ren_ok    = bus.ren_req & clk_en & in_batch & (count_ren < depth);
  assign bus.wen_ok = wen_ok;
  assign bus.ren_ok = ren_ok;

  assign wnext     = count_wen + CNT_W'(wen_ok);
  assign rnext     = count_ren + CNT_W'(ren_ok);
  assign w_full    = (wnext == depth);
  assign r_full    = (rnext == depth);
  assign batch_cmp = in_batch & w_full & r_full;

  // per-batch counters; both clear together when the batch completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_wen  <= '0;
      count_ren  <= '0;
      batch_done <= 1'b0;
    end else begin
      batch_done <= clk_en & batch_cmp;
      if (clk_en) begin
        if (batch_cmp) begin
          count_wen <= '0;
          count_ren <= '0;
        end else begin
          count_wen <= wnext;
          count_ren <= rnext;
        end
      end
    end
  end

  aqed_sat_cnt #(.W(BND_W)) u_out_after (
    .clk     (clk),
    .reset   (reset),
    .en      (clk_en),
    .clr     (1'b0),
    .inc     (ren_ok & bus.orig_issued),
    .cnt_nxt (out_nxt)
  );

  aqed_sat_cnt #(.W(BND_W)) u_in_after (
    .clk     (clk),
    .reset   (reset),
    .en      (clk_en),
    .clr     (1'b0),
    .inc     (wen_ok & bus.orig_issued),
    .cnt_nxt (in_nxt)
  );

  // threshold compared against post-edge counts so the error lands on the
  // edge that admits the last read/write; a same-cycle orig_done still wins
  assign bound_thr = BND_W'(depth) << OR_LOG2;
  assign bound_set = (depth != '0) & (out_nxt >= bound_thr) &
                     (in_nxt >= BND_W'(depth)) & ~rdy_seen & ~bus.orig_done;

  // sticky completion-seen and bound error flags (not gated by clk_en)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_seen  <= 1'b0;
      bound_err <= 1'b0;
    end else begin
      rdy_seen  <= rdy_seen | bus.orig_done;
      bound_err <= bound_err | bound_set;
    end
  end

`ifdef AQED_BATCH_MON_WDOG_EN
  logic [WDOG_W-1:0] wdog_nxt;

  aqed_sat_cnt #(.W(WDOG_W)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .en      (clk_en),
    .clr     ((st_q == ST_IDLE) | wen_ok | ren_ok),
    .inc     (in_batch & (bus.wen_req | bus.ren_req) & ~wen_ok & ~ren_ok),
    .cnt_nxt (wdog_nxt)
  );

  assign wdog_set = &wdog_nxt;

  // sticky watchdog timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= wdog_err | wdog_set;
    end
  end
`else
  assign wdog_set = 1'b0;
  assign wdog_err = 1'b0;
`endif

  // FSM next state: error entry ignores clk_en, everything else waits for it
  always_comb begin
    st_d = st_q;
    if (bound_set | wdog_set) begin
      st_d = ST_ERR;
    end else if (clk_en) begin
      unique case (st_q)
        ST_IDLE: begin
          if (depth != '0) st_d = ST_ACTIVE;
        end
        ST_ACTIVE, ST_HOLD: begin
          if (batch_cmp) begin
            st_d = (depth == '0) ? ST_IDLE : ST_ACTIVE;
          end else if (w_full ^ r_full) begin
            st_d = ST_HOLD;
          end
        end
        default: st_d = st_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  assign state = st_q;

endmodule
